// File: rtl/move_input_ctrl.sv
// Move input controller: synchronizes and debounces the two drop buttons, reads the
// column switches and offers one legal move at a time to the board stage.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLK50,
    input  logic       Reset_button,
    input  logic       P1,
    input  logic       P2,
    input  logic       Sw6,
    input  logic       Sw5,
    input  logic       Sw4,
    input  logic       Sw3,
    input  logic       Sw2,
    input  logic       Sw1,
    input  logic       Sw0,
    input  logic [6:0] col_full,
    input  logic       lock,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_col,
    output logic       move_player,
    output logic       turn,
    output logic       err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    function automatic logic is_onehot7(input logic [6:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

    function automatic logic [2:0] col_index(input logic [6:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t           state_r;
    logic [1:0]       btn_raw_s;
    logic [6:0]       sw_raw_s;
    logic [1:0]       btn_meta_r;
    logic [1:0]       btn_sync_r;
    logic [6:0]       sw_meta_r;
    logic [6:0]       sw_sync_r;
    logic [1:0]       btn_deb_r;
    logic [1:0]       btn_deb_q_r;
    logic [CNT_W-1:0] cnt_r [2];
    logic [1:0]       press_s;
    logic             cur_press_s;
    logic             legal_s;
    logic [2:0]       sel_col_s;

    // Bit 0 is player 1, bit 1 is player 2, matching the turn encoding.
    assign btn_raw_s = {P2, P1};
    assign sw_raw_s  = {Sw6, Sw5, Sw4, Sw3, Sw2, Sw1, Sw0};

    // Two-flop synchronizers for all raw asynchronous inputs.
    always_ff @(posedge CLK50 or negedge Reset_button) begin
        if (!Reset_button) begin
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
            sw_meta_r  <= 7'b0000000;
            sw_sync_r  <= 7'b0000000;
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_raw_s;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Per-button debounce: level flips on the edge the counter would hit DEBOUNCE_CYCLES.
    always_ff @(posedge CLK50 or negedge Reset_button) begin
        if (!Reset_button) begin
            btn_deb_r   <= 2'b00;
            btn_deb_q_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            btn_deb_q_r <= btn_deb_r;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] == btn_deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i]     <= '0;
                    btn_deb_r[i] <= btn_sync_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press detection and legality of the currently selected column.
    always_comb begin
        press_s     = btn_deb_r & ~btn_deb_q_r;
        cur_press_s = turn ? press_s[1] : press_s[0];
        sel_col_s   = col_index(sw_sync_r);
        legal_s     = ~lock & is_onehot7(sw_sync_r) & ~(|(col_full & sw_sync_r));
    end

    // Move FSM; the other player's presses never reach it, so they raise no error.
    always_ff @(posedge CLK50 or negedge Reset_button) begin
        if (!Reset_button) begin
            state_r     <= IDLE;
            move_valid  <= 1'b0;
            move_col    <= 3'd0;
            move_player <= 1'b0;
            turn        <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cur_press_s && legal_s) begin
                        move_col    <= sel_col_s;
                        move_player <= turn;
                        move_valid  <= 1'b1;
                        state_r     <= PENDING;
                    end else if (cur_press_s) begin
                        err <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PENDING: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        turn       <= ~turn;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= PENDING;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl with DEBOUNCE_CYCLES = 4: stimulus queues the
// expected moves/errors, a negedge monitor pops and compares them as the DUT presents them.
module tb_move_input_ctrl;

    localparam int DC = 4;

    typedef struct packed {
        logic       is_err;
        logic [2:0] col;
        logic       player;
    } exp_t;

    logic       clk = 1'b0;
    logic       Reset_button = 1'b0;
    logic       P1 = 1'b0;
    logic       P2 = 1'b0;
    logic [6:0] sw = 7'b0000000;
    logic [6:0] col_full = 7'b0000000;
    logic       lock = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [2:0] move_col;
    logic       move_player;
    logic       turn;
    logic       err;

    int   passed = 0;
    int   total = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic hold_chk = 1'b0;
    logic hold_bad = 1'b0;

    move_input_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK50(clk), .Reset_button(Reset_button), .P1(P1), .P2(P2),
        .Sw6(sw[6]), .Sw5(sw[5]), .Sw4(sw[4]), .Sw3(sw[3]),
        .Sw2(sw[2]), .Sw1(sw[1]), .Sw0(sw[0]),
        .col_full(col_full), .lock(lock), .move_ready(move_ready),
        .move_valid(move_valid), .move_col(move_col), .move_player(move_player),
        .turn(turn), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [2:0] col, input logic player);
        exp_t e;
        e.is_err = is_err;
        e.col    = col;
        e.player = player;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic p2, input int hold);
        if (p2) P2 = 1'b1; else P1 = 1'b1;
        tick(hold);
        P1 = 1'b0;
        P2 = 1'b0;
        tick(12);
    endtask

    task automatic do_reset();
        Reset_button = 1'b0;
        #1;
        check("rst_valid", 32'(move_valid), 32'd0);
        check("rst_turn", 32'(turn), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick(2);
        Reset_button = 1'b1;
        tick(1);
    endtask

    task automatic count_valid(input int cycles, output int hi);
        hi = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (move_valid) hi++;
        end
    endtask

    task automatic wait_valid(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick(1);
            if (move_valid) found = 1'b1;
        end
    endtask

    // Scoreboard monitor: every transfer and every error pulse must match the queue head.
    always @(negedge clk) begin
        if (Reset_button && move_valid && move_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_move: got col %0d player %0d, required none", move_col, move_player);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_move_col", 32'({1'b0, move_col}), 32'({mon_e.is_err, mon_e.col}));
                check("mon_move_player", 32'(move_player), 32'(mon_e.player));
            end
        end
        if (Reset_button && err) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_err: got err with turn %0d, required none", turn);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_err", 32'({1'b1, turn}), 32'({mon_e.is_err, mon_e.player}));
            end
        end
        if (hold_chk && !(move_valid && move_col == 3'd6 && move_player == 1'b1)) begin
            hold_bad = 1'b1;
        end
    end

    initial begin
        int   first;
        int   hi;
        logic found;

        // Reset state and first-move latency.
        #2;
        check("rst_valid0", 32'(move_valid), 32'd0);
        check("rst_col0", 32'(move_col), 32'd0);
        check("rst_player0", 32'(move_player), 32'd0);
        check("rst_turn0", 32'(turn), 32'd0);
        check("rst_err0", 32'(err), 32'd0);
        tick(2);
        Reset_button = 1'b1;
        sw = 7'b0001000;
        move_ready = 1'b1;
        tick(4);
        push_exp(1'b0, 3'd3, 1'b0);
        P1 = 1'b1;
        first = 0;
        hi = 0;
        for (int n = 1; n <= 10; n++) begin
            tick(1);
            if (move_valid) begin
                if (first == 0) begin
                    first = n;
                    check("t1_col", 32'(move_col), 32'd3);
                    check("t1_player", 32'(move_player), 32'd0);
                end
                hi++;
            end
        end
        P1 = 1'b0;
        check("t1_latency", 32'(first), 32'(DC + 3));
        check("t1_width", 32'(hi), 32'd1);
        check("t1_turn", 32'(turn), 32'd1);
        tick(12);

        // Bouncing input then steady level: exactly one move.
        do_reset();
        sw = 7'b0100000;
        tick(3);
        push_exp(1'b0, 3'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            P1 = 1'b1;
            tick(2);
            P1 = 1'b0;
            tick(2);
        end
        P1 = 1'b1;
        count_valid(30, hi);
        P1 = 1'b0;
        check("t2_one_move", 32'(hi), 32'd1);
        tick(12);
        check("t2_turn", 32'(turn), 32'd1);

        // Two switches high: error for the current player, silence for the other.
        do_reset();
        sw = 7'b0100100;
        tick(3);
        push_exp(1'b1, 3'd0, 1'b0);
        press(1'b0, 10);
        press(1'b1, 10);
        check("t3_turn", 32'(turn), 32'd0);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // Full column, then lock, then the same column legal (column 0 boundary).
        sw = 7'b0000001;
        col_full = 7'b0000001;
        tick(3);
        push_exp(1'b1, 3'd0, 1'b0);
        press(1'b0, 10);
        col_full = 7'b0000000;
        lock = 1'b1;
        push_exp(1'b1, 3'd0, 1'b0);
        press(1'b0, 10);
        lock = 1'b0;
        push_exp(1'b0, 3'd0, 1'b0);
        press(1'b0, 10);
        check("t4_turn", 32'(turn), 32'd1);
        check("t4_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure: outputs hold, presses ignored, then one transfer.
        move_ready = 1'b0;
        sw = 7'b1000000;
        tick(3);
        P2 = 1'b1;
        wait_valid(20, found);
        check("t5_valid_seen", 32'(found), 32'd1);
        check("t5_col", 32'(move_col), 32'd6);
        check("t5_player", 32'(move_player), 32'd1);
        hold_chk = 1'b1;
        P2 = 1'b0;
        tick(10);
        press(1'b0, 10);
        press(1'b1, 10);
        hold_chk = 1'b0;
        check("t5_hold_stable", 32'(hold_bad), 32'd0);
        check("t5_turn_held", 32'(turn), 32'd1);
        push_exp(1'b0, 3'd6, 1'b1);
        move_ready = 1'b1;
        tick(1);
        check("t5_valid_clr", 32'(move_valid), 32'd0);
        check("t5_turn_toggle", 32'(turn), 32'd0);
        count_valid(5, hi);
        check("t5_no_repeat", 32'(hi), 32'd0);

        // Reset while pending discards the move.
        move_ready = 1'b0;
        sw = 7'b0000010;
        tick(3);
        P1 = 1'b1;
        wait_valid(20, found);
        check("t6_valid_seen", 32'(found), 32'd1);
        P1 = 1'b0;
        Reset_button = 1'b0;
        #1;
        check("t6_rst_valid", 32'(move_valid), 32'd0);
        check("t6_rst_turn", 32'(turn), 32'd0);
        tick(2);
        move_ready = 1'b1;
        Reset_button = 1'b1;
        count_valid(20, hi);
        check("t6_no_transfer", 32'(hi), 32'd0);

        // Button held through reset: one press after release.
        Reset_button = 1'b0;
        P1 = 1'b1;
        tick(2);
        push_exp(1'b0, 3'd1, 1'b0);
        Reset_button = 1'b1;
        count_valid(20, hi);
        P1 = 1'b0;
        check("t7_one_move", 32'(hi), 32'd1);
        tick(12);
        check("t7_turn", 32'(turn), 32'd1);

        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
